multi_debouncer: RTL
====================

MULTI_DEBOUNCER -- requirements
Module: multi_debouncer

Interface
REQ-001 Parameter N_CH, default 4, number of independent button channels (1..32).
REQ-002 Parameter CNT_W, default 16, width of the per-channel stability counter.
REQ-003 Parameter STABLE_CNT, default 50000, consecutive disagreeing cycles needed to toggle the debounced level; legal range 2..2^CNT_W.
REQ-004 Parameter ACTIVE_LOW, default 0; 1 = raw input low means pressed.
REQ-005 Parameter LONG_W, default 26, width of the per-channel hold counter.
REQ-006 Parameter LONG_CYCLES, default 50000000, debounced-pressed cycles before the long-press pulse; legal range 1..2^LONG_W-1.
REQ-007 clk  input  1  single clock; all state on rising edge.
REQ-008 rst  input  1  asynchronous, active-high reset.
REQ-009 button  input  N_CH  raw asynchronous button inputs, one bit per channel.
REQ-010 btn_level  output  N_CH  debounced pressed level (1 = pressed), registered.
REQ-011 btn_rise  output  N_CH  one-cycle pulse on debounced press.
REQ-012 btn_fall  output  N_CH  one-cycle pulse on debounced release.
REQ-013 btn_long  output  N_CH  one-cycle pulse once per press when held LONG_CYCLES.
REQ-014 any_rise  output  1  OR-reduction of btn_rise, registered in the same cycle as btn_rise.

Function
REQ-015 Each channel shall pass its input (inverted when ACTIVE_LOW=1) through a two-flop synchronizer; sync values denote "pressed".
REQ-016 Channels shall be fully independent; no shared counters or arbitration.
REQ-017 When sync output equals btn_level, the stability counter shall clear to 0 on that edge.
REQ-018 When they differ and counter < STABLE_CNT-1, counter shall increment by 1.
REQ-019 When they differ and counter == STABLE_CNT-1, btn_level shall toggle and counter shall clear to 0 on that edge.
REQ-020 Latency: a clean input change shall appear on btn_level exactly STABLE_CNT+2 rising edges after (and including) the first edge sampling the new value.
REQ-021 Any bounce back to the current btn_level before the toggle edge shall clear the counter; btn_level shall not change.
REQ-022 btn_rise/btn_fall shall assert on the same edge btn_level toggles 0->1 / 1->0, for exactly one cycle; never both high on one channel.
REQ-023 Counter arithmetic shall never wrap; STABLE_CNT-1 is the maximum value reached.
REQ-024 Hold counter (LONG_PRESS_EN only): cleared while btn_level=0; increments each cycle btn_level=1 until it reaches LONG_CYCLES, then saturates.
REQ-025 btn_long shall pulse one cycle on the edge the hold counter transitions LONG_CYCLES-1 -> LONG_CYCLES; a release clears it so the next press may fire again.
REQ-026 A release on the same edge the hold counter would reach LONG_CYCLES shall suppress btn_long.

Reset
REQ-027 rst high shall immediately clear synchronizer flops, stability and hold counters, btn_level, btn_rise, btn_fall, btn_long and any_rise to 0, regardless of clk.
REQ-028 Reset mid-bounce or mid-hold shall discard progress; after release from reset a held button shall take the full REQ-020 latency and produce a fresh btn_rise.

Configuration
REQ-029 Macro LONG_PRESS_EN defined: hold counters and btn_long behave per REQ-024..026.
REQ-030 Macro LONG_PRESS_EN undefined: no hold counters are built; btn_long shall be constant 0; port list unchanged.

Verification (N_CH=2, STABLE_CNT=4, LONG_CYCLES=10, LONG_PRESS_EN defined unless stated)
REQ-031 button[0] 0->1 clean -> btn_level[0]=1 and btn_rise[0]=1 on the 6th edge, btn_rise[0]=0 next cycle; channel 1 stays 0.
REQ-032 button[0] pulses high for 3 synchronized cycles, then low -> btn_level[0], btn_rise[0] never assert.
REQ-033 Hold button[1]=1 for 30 cycles -> btn_long[1] single pulse exactly 10 cycles after btn_rise[1]; release -> btn_fall[1] 6 edges after input drop; second press fires btn_long again.
REQ-034 ACTIVE_LOW=1, button=2'b11 idle, drive button[0]=0 -> btn_level[0]=1 after 6 edges; any_rise pulses with btn_rise[0].
REQ-035 Assert rst asynchronously while btn_level=2'b11 and counters mid-count -> all outputs 0 before next clk edge; inputs still pressed -> btn_rise 6 edges after rst release.
REQ-036 LONG_PRESS_EN undefined, hold button[0] for 50 cycles -> btn_long stays 0, level/rise/fall unchanged from REQ-031.

Source files
------------

// File: rtl/multi_debouncer.sv
// Multi-channel button debouncer: 2-flop sync, per-channel stability counter, edge pulses.
// Optional long-press detection is built only when LONG_PRESS_EN is defined.
module multi_debouncer #(
    parameter int unsigned N_CH        = 4,
    parameter int unsigned CNT_W       = 16,
    parameter int unsigned STABLE_CNT  = 50000,
    parameter bit          ACTIVE_LOW  = 1'b0,
    parameter int unsigned LONG_W      = 26,
    parameter int unsigned LONG_CYCLES = 50000000
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N_CH-1:0] button,
    output logic [N_CH-1:0] btn_level,
    output logic [N_CH-1:0] btn_rise,
    output logic [N_CH-1:0] btn_fall,
    output logic [N_CH-1:0] btn_long,
    output logic            any_rise
);

    if (N_CH < 1 || N_CH > 32) begin : g_bad_n_ch
        $error("multi_debouncer: N_CH must be 1..32");
    end
    if (STABLE_CNT < 2 || 64'(STABLE_CNT) > (64'd1 << CNT_W)) begin : g_bad_stable
        $error("multi_debouncer: STABLE_CNT must be 2..2^CNT_W");
    end
    if (LONG_CYCLES < 1 || 64'(LONG_CYCLES) > ((64'd1 << LONG_W) - 64'd1)) begin : g_bad_long
        $error("multi_debouncer: LONG_CYCLES must be 1..2^LONG_W-1");
    end

    localparam logic [CNT_W-1:0] STABLE_MAX = CNT_W'(STABLE_CNT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

    logic [N_CH-1:0]  pressed_raw;
    logic [N_CH-1:0]  sync1_q;
    logic [N_CH-1:0]  sync2_q;
    logic [CNT_W-1:0] cnt_q [N_CH];
    logic [CNT_W-1:0] cnt_d [N_CH];
    logic [N_CH-1:0]  level_q;
    logic [N_CH-1:0]  level_d;
    logic [N_CH-1:0]  rise_q;
    logic [N_CH-1:0]  rise_d;
    logic [N_CH-1:0]  fall_q;
    logic [N_CH-1:0]  fall_d;
    logic             any_rise_q;

    assign pressed_raw = ACTIVE_LOW ? ~button : button;

    // Counter tracks consecutive cycles the synchronized input disagrees with the level.
    always_comb begin
        level_d = level_q;
        rise_d  = '0;
        fall_d  = '0;
        for (int i = 0; i < int'(N_CH); i++) begin
            cnt_d[i] = '0;
            if (sync2_q[i] != level_q[i]) begin
                if (cnt_q[i] == STABLE_MAX) begin
                    level_d[i] = ~level_q[i];
                    rise_d[i]  = ~level_q[i];
                    fall_d[i]  = level_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + CNT_ONE;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q    <= '0;
            sync2_q    <= '0;
            level_q    <= '0;
            rise_q     <= '0;
            fall_q     <= '0;
            any_rise_q <= 1'b0;
            for (int i = 0; i < int'(N_CH); i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            sync1_q    <= pressed_raw;
            sync2_q    <= sync1_q;
            level_q    <= level_d;
            rise_q     <= rise_d;
            fall_q     <= fall_d;
            any_rise_q <= |rise_d;
            for (int i = 0; i < int'(N_CH); i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign btn_level = level_q;
    assign btn_rise  = rise_q;
    assign btn_fall  = fall_q;
    assign any_rise  = any_rise_q;

`ifdef LONG_PRESS_EN
    localparam logic [LONG_W-1:0] LONG_MAX  = LONG_W'(LONG_CYCLES);
    localparam logic [LONG_W-1:0] LONG_LAST = LONG_W'(LONG_CYCLES - 1);
    localparam logic [LONG_W-1:0] LONG_ONE  = LONG_W'(1);

    logic [LONG_W-1:0] hold_q [N_CH];
    logic [LONG_W-1:0] hold_d [N_CH];
    logic [N_CH-1:0]   long_q;
    logic [N_CH-1:0]   long_d;

    // Counting needs the level held both before and after this edge, so a release
    // landing on the terminal edge suppresses the pulse.
    always_comb begin
        long_d = '0;
        for (int i = 0; i < int'(N_CH); i++) begin
            hold_d[i] = '0;
            if (level_q[i] && level_d[i]) begin
                if (hold_q[i] != LONG_MAX) begin
                    hold_d[i] = hold_q[i] + LONG_ONE;
                    long_d[i] = (hold_q[i] == LONG_LAST);
                end else begin
                    hold_d[i] = hold_q[i];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            long_q <= '0;
            for (int i = 0; i < int'(N_CH); i++) begin
                hold_q[i] <= '0;
            end
        end else begin
            long_q <= long_d;
            for (int i = 0; i < int'(N_CH); i++) begin
                hold_q[i] <= hold_d[i];
            end
        end
    end

    assign btn_long = long_q;
`else
    assign btn_long = '0;
`endif

endmodule
